// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES types, constants and round tables
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef logic [63:0] block_t;
    typedef logic [47:0] subkey_t;
    typedef subkey_t [0:15] key_sched_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    // S-boxes S1..S8, each 4 rows x 16 columns, addressed as [box][{row, col}]
    localparam logic [0:7][0:63][3:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P permutation: output bit n (1 = MSB) takes S-box output bit P_TABLE[n-1]
    localparam logic [0:31][5:0] P_TABLE = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

endpackage

// File: rtl/des_round_chain.sv
// rtl/des_round_chain.sv - ROUNDS_PER_CYCLE chained DES rounds evaluated in one cycle
module des_round_chain
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic [63:0]                         block,
    input  logic [0:ROUNDS_PER_CYCLE-1][47:0]   subkeys,
    output logic [63:0]                         result
);

    block_t stage [0:ROUNDS_PER_CYCLE];

    assign stage[0] = block;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        round u_round (
            .block      (stage[i]),
            .subkey     (subkeys[i]),
            .next_block (stage[i + 1])
        );
    end

    assign result = stage[ROUNDS_PER_CYCLE];

endmodule

// File: rtl/round.sv
// rtl/round.sv - one DES Feistel round: {L,R} -> {R, L ^ f(R,K)}
module round
    import des_pkg::*;
(
    input  logic [63:0] block,
    input  logic [47:0] subkey,
    output logic [63:0] next_block
);

    logic [47:0] expanded;
    logic [31:0] substituted;
    logic [31:0] f_out;
    logic [5:0]  six;
    logic [4:0]  pidx;

    // f-function: expand R, mix subkey, substitute through S-boxes, permute
    always_comb begin
        expanded    = '0;
        substituted = '0;
        f_out       = '0;
        six         = '0;
        pidx        = '0;
        // group g copies R bits 4g..4g+5 (1 = MSB, wrapping), i.e. overlapping 6-bit windows
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 6; k++) begin
                expanded[47 - (6 * g + k)] = block[31 - ((4 * g + k + 31) % 32)];
            end
        end
        for (int g = 0; g < 8; g++) begin
            six = expanded[47 - 6 * g -: 6] ^ subkey[47 - 6 * g -: 6];
            // outer bits select the row, inner four the column
            substituted[31 - 4 * g -: 4] = SBOX[g][{six[5], six[0], six[4:1]}];
        end
        for (int n = 0; n < 32; n++) begin
            pidx = 5'(6'd32 - P_TABLE[n]);
            f_out[31 - n] = substituted[pidx];
        end
    end

    assign next_block = {block[31:0], block[63:32] ^ f_out};

endmodule

// File: rtl/des_round_sequencer.sv
// rtl/des_round_sequencer.sv - iterative DES round controller reusing a short round chain
module des_round_sequencer
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_block,
    input  logic                in_decrypt,
    input  logic [0:15][47:0]   in_round_keys,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_block,
    output logic                busy,
    output logic [3:0]          round_idx
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    seq_state_t state_q, state_d;
    block_t     data_q;
    key_sched_t keys_q;
    logic       decrypt_q;
    logic [4:0] cnt_q;
    logic       accept;
    logic       last_step;
    logic [3:0] key_round;
    block_t     chain_out;
    logic [0:ROUNDS_PER_CYCLE-1][47:0] key_slice;

    assign last_step = (cnt_q == 5'(DES_ROUNDS - ROUNDS_PER_CYCLE));

    // pick the subkeys for rounds cnt..cnt+N-1; decrypt walks the schedule backwards
    always_comb begin
        key_slice = '0;
        key_round = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            key_round = cnt_q[3:0] + 4'(j);
            key_slice[j] = decrypt_q ? keys_q[4'd15 - key_round] : keys_q[key_round];
        end
    end

    des_round_chain #(
        .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
    ) u_chain (
        .block   (data_q),
        .subkeys (key_slice),
        .result  (chain_out)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake outputs; result is exposed only in DONE
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_block = '0;
        busy      = 1'b0;
        round_idx = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                round_idx = cnt_q[3:0];
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_block = {data_q[31:0], data_q[63:32]};
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath: capture request on accept, otherwise advance the rounds while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            keys_q    <= '0;
            decrypt_q <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            data_q    <= in_block;
            keys_q    <= in_round_keys;
            decrypt_q <= in_decrypt;
            cnt_q     <= '0;
        end else if (state_q == RUN) begin
            data_q    <= chain_out;
            cnt_q     <= cnt_q + 5'(ROUNDS_PER_CYCLE);
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb/tb_des_round_sequencer.sv - self-checking bench for des_round_sequencer
module tb_des_round_sequencer;

    localparam int RPC = 1;
    localparam int LAT = 16 / RPC;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_block;
    logic               in_decrypt;
    logic [0:15][47:0]  in_round_keys;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_block;
    logic               busy;
    logic [3:0]         round_idx;

    int n_checks = 0;
    int n_fail   = 0;

    des_round_sequencer #(
        .ROUNDS_PER_CYCLE (RPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_block      (in_block),
        .in_decrypt    (in_decrypt),
        .in_round_keys (in_round_keys),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_block     (out_block),
        .busy          (busy),
        .round_idx     (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS example: subkeys K1..K16 of key 133457799BBCDFF1,
    // IP(0123456789ABCDEF) and IP(85E813540F0AB405) = {R16,L16}
    logic [0:15][47:0] fips_k = {
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    localparam logic [63:0] FIPS_IP_PT = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [63:0] FIPS_IP_CT = 64'h0A4CD995_43423234;

    int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                       12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                       22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    logic [255:0] s_rows [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  x;
        logic [31:0]  s;
        logic [31:0]  p;
        logic [255:0] box;
        int row;
        int col;
        for (int n = 0; n < 48; n++) x[47 - n] = r[32 - e_tab[n]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            row = 2 * int'(x[47 - 6 * i]) + int'(x[42 - 6 * i]);
            col = 8 * int'(x[46 - 6 * i]) + 4 * int'(x[45 - 6 * i])
                + 2 * int'(x[44 - 6 * i]) + int'(x[43 - 6 * i]);
            box = s_rows[i];
            s[31 - 4 * i -: 4] = box[255 - 4 * (16 * row + col) -: 4];
        end
        for (int n = 0; n < 32; n++) p[31 - n] = s[32 - p_tab[n]];
        return p;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] blk,
                                            input logic [0:15][47:0] keys,
                                            input logic dec);
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_ref(r, dec ? keys[15 - i] : keys[i]);
            l = t;
        end
        return {r, l};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_keys(output logic [0:15][47:0] k);
        logic [63:0] t;
        for (int i = 0; i < 16; i++) begin
            t = {$urandom(), $urandom()};
            k[i] = t[47:0];
        end
    endtask

    // garbage on the request lines while the block must ignore them
    task automatic scramble();
        logic [0:15][47:0] k;
        rand_keys(k);
        in_block      = {$urandom(), $urandom()};
        in_round_keys = k;
        in_decrypt    = 1'($urandom());
    endtask

    task automatic send(input logic [63:0] blk, input logic [0:15][47:0] keys, input logic dec);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 64) begin
            tick();
            guard++;
        end
        chk("accept_ready", 64'(in_ready), 64'h1);
        in_valid      = 1'b1;
        in_block      = blk;
        in_round_keys = keys;
        in_decrypt    = dec;
        tick();
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_result(input string tag, input logic [63:0] exp);
        int n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            chk({tag, "_run_out_block"}, out_block, 64'h0);
            chk({tag, "_round_idx"}, 64'(round_idx), 64'(n * RPC));
            chk({tag, "_run_busy"}, 64'(busy), 64'h1);
            chk({tag, "_run_in_ready"}, 64'(in_ready), 64'h0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_result"}, out_block, exp);
        chk({tag, "_done_in_ready"}, 64'(in_ready), 64'(out_ready));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'h0);
        chk("drain_out_block", out_block, 64'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_out_block"}, out_block, 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_round_idx"}, 64'(round_idx), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15][47:0] k;
        logic [0:15][47:0] k2;
        logic [63:0] blk;
        logic [63:0] blk2;
        logic [63:0] exp;
        logic        dec;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_block      = '0;
        in_decrypt    = 1'b0;
        in_round_keys = '0;
        out_ready     = 1'b0;
        #12;
        check_reset_values("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("idle");

        // reference model anchored on the FIPS example
        chk("model_fips_enc", des_ref(FIPS_IP_PT, fips_k, 1'b0), FIPS_IP_CT);
        chk("model_fips_dec", des_ref(FIPS_IP_CT, fips_k, 1'b1), FIPS_IP_PT);

        send(FIPS_IP_PT, fips_k, 1'b0);
        wait_result("fips_enc", FIPS_IP_CT);
        drain();

        send(FIPS_IP_CT, fips_k, 1'b1);
        wait_result("fips_dec", FIPS_IP_PT);
        drain();

        // random blocks, keys and direction, with occasional result backpressure
        for (int t = 0; t < 200; t++) begin
            rand_keys(k);
            blk = {$urandom(), $urandom()};
            dec = 1'($urandom());
            exp = des_ref(blk, k, dec);
            send(blk, k, dec);
            wait_result("random", exp);
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                tick();
                chk("random_hold_block", out_block, exp);
            end
            drain();
        end

        // backpressure in DONE, then back-to-back accept as out_ready rises
        rand_keys(k);
        blk = {$urandom(), $urandom()};
        exp = des_ref(blk, k, 1'b0);
        send(blk, k, 1'b0);
        wait_result("bp", exp);
        rand_keys(k2);
        blk2 = {$urandom(), $urandom()};
        in_valid      = 1'b1;
        in_block      = blk2;
        in_round_keys = k2;
        in_decrypt    = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("bp_hold_block", out_block, exp);
            chk("bp_hold_valid", 64'(out_valid), 64'h1);
            chk("bp_hold_in_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'h1);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        scramble();
        chk("b2b_out_valid", 64'(out_valid), 64'h0);
        wait_result("b2b", des_ref(blk2, k2, 1'b1));
        drain();

        // asynchronous reset part-way through the rounds
        send(FIPS_IP_PT, fips_k, 1'b0);
        for (int h = 0; h < 7 / RPC; h++) tick();
        chk("midrun_round_idx", 64'(round_idx), 64'((7 / RPC) * RPC));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        rst_n = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            check_reset_values("post_reset");
        end
        send(FIPS_IP_PT, fips_k, 1'b0);
        wait_result("fips_after_reset", FIPS_IP_CT);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
Iterative DES core controller. It replaces the fully unrolled 16-stage combinational round chain with ROUNDS_PER_CYCLE instances of the existing `round` module, and reuses them over 16/ROUNDS_PER_CYCLE clock cycles. It accepts a post-initial-permutation block plus 16 subkeys over a valid/ready handshake. It selects the subkey order for encrypt or decrypt and returns the swapped (R16,L16) block ready for the final permutation. It sits between the initial permutation and key schedule on the input side and the final permutation on the output side.

Parameters:
ROUNDS_PER_CYCLE, 1, number of chained `round` instances evaluated per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  input  1  system clock; the block uses one clock.
rst_n  input  1  reset; the block uses one clock, and reset is asynchronous and active-low.
in_valid  input  1  request carries a valid block.
in_ready  output  1  block can accept a request this cycle.
in_block  input  64  post-IP text, {L0,R0}.
in_decrypt  input  1  1 = apply subkeys 15..0; 0 = apply subkeys 0..15.
in_round_keys  input  [0:15][47:0]  subkeys K1..K16 in index order 0..15.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_block  output  64  {R16,L16}, goes to the final permutation.
busy  output  1  high in RUN or DONE.
round_idx  output  4  index of the first round evaluated in the current cycle; 0 when not in RUN.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0, round_idx=0. Internal data, key and counter registers clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_block, in_round_keys and in_decrypt, set cnt=0, and go to RUN.
- RUN:
  - Each cycle, apply the subkeys for rounds cnt..cnt+ROUNDS_PER_CYCLE-1 through the chain and register the 64-bit result.
  - Then cnt += ROUNDS_PER_CYCLE.
  - When the rounds applied in a cycle include round 15, go to DONE.
  - in_ready=0 throughout RUN.
- Subkey select for round r: encrypt uses keys[r]; decrypt uses keys[15-r]. The key register is not modified during RUN.
- DONE:
  - out_valid=1.
  - out_block = {state_reg[31:0], state_reg[63:32]} (final L/R swap).
  - If out_ready=1: complete the output handshake. If in_valid is also high in the same cycle, accept the new request and go directly to RUN with cnt=0; otherwise go to IDLE.
  - in_ready = out_ready while in DONE.
- Latency: accept at cycle T gives out_valid=1 at T + 16/ROUNDS_PER_CYCLE. With ROUNDS_PER_CYCLE=1 this is 16 cycles; with 16 it is 1 cycle.
- Throughput under continuous out_ready=1: one block per 16/ROUNDS_PER_CYCLE + 1 cycles. The extra cycle is the DONE cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_block and out_valid hold stable and in_ready=0.
- in_* signals are ignored whenever in_ready=0. Keys are sampled only at acceptance.
- Counter: 5-bit internally. It never exceeds 16, and there is no wrap-around into round 0.
- Reset asserted mid-operation: the block returns immediately (asynchronously) to the reset values above. Any in-flight block is discarded and no partial result is emitted.
- out_block is 0 whenever out_valid=0; it must not leak intermediate rounds.

Decomposition:
- Shared package des_pkg holds:
  - typedefs block_t (64b), subkey_t (48b) and key_sched_t ([0:15] subkey_t);
  - constant DES_ROUNDS=16;
  - enum seq_state_t {IDLE,RUN,DONE}.
- One sub-module, des_round_chain:
  - generate-chains ROUNDS_PER_CYCLE instances of the existing `round`;
  - inputs: a block and a ROUNDS_PER_CYCLE-wide subkey slice; output: the block after the last instance.
- The sequencer holds the FSM, the counter, the key-order mux and the registers.

Test Plan:
- FIPS vector, encrypt: key 133457799BBCDFF1, plaintext 0123456789ABCDEF, wrapped with the existing IP, FP and key schedule. Response: ciphertext 85E813540F0AB405, with out_valid exactly 16 cycles after acceptance (ROUNDS_PER_CYCLE=1).
- Decrypt: same key, input 85E813540F0AB405 with in_decrypt=1. Response: output 0123456789ABCDEF.
- Parameter sweep and cross-check: ROUNDS_PER_CYCLE in {1,2,4,8,16}, 1000 random blocks and keys, compared against the combinational 16-round stack. Response: bit-exact results; latency 16, 8, 4, 2, 1 respectively.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE. Response: out_block stable, in_ready=0.
  - Then raise out_ready with in_valid=1. Response: the new block is accepted in the same cycle, and its result arrives at +16.
- Reset mid-RUN: drop rst_n at round 7. Response: out_valid=0, in_ready=1 and round_idx=0 immediately. A subsequent FIPS encrypt then still yields 85E813540F0AB405.
- Ignored inputs: change in_block and in_round_keys during RUN. Response: the result matches the originally accepted inputs.
